// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry prefetch FIFO feeding decode.
// Issues word-aligned fetches (one outstanding at most), buffers {instr, pc} pairs,
// and flushes/restarts on redirect. Optional macro FQ_STALL_CNT_EN adds a saturating
// counter of cycles where decode was ready but no instruction was available.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
`ifdef FQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t         state;
  logic [15:0]    fetch_pc;
  logic [15:0]    req_pc;
  logic [15:0]    fifo_instr [DEPTH];
  logic [15:0]    fifo_pc    [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  logic           wait_rsp;
  logic [OW-1:0]  occupancy;
  logic           space;
  logic           grant;
  logic           push;
  logic           pop;

  // Request gating, handshake decode and head-of-queue outputs
  always_comb begin
    wait_rsp    = (state == S_WAIT) && mem_rvalid;
    // An outstanding fetch already owns a slot, whether or not its data lands this cycle
    occupancy   = OW'(count) + OW'(state != S_IDLE);
    space       = occupancy < OW'(DEPTH);
    mem_req     = reset && !redirect && space && ((state == S_IDLE) || wait_rsp);
    mem_addr    = fetch_pc;
    grant       = mem_req && mem_gnt;
    push        = wait_rsp && !redirect;
    instr_valid = (count != '0) && !redirect;
    pop         = instr_valid && instr_ready;
    instr       = fifo_instr[rd_ptr];
    instr_pc    = fifo_pc[rd_ptr];
  end

  // Fetch FSM, PC tracking and FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect) begin
      // Flush wins over everything; an in-flight fetch becomes a response to discard
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc & 16'hFFFE;
      if (state == S_IDLE || mem_rvalid) begin
        state <= S_IDLE;
      end else begin
        state <= S_DROP;
      end
    end else begin
      if (grant) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 16'd2;
      end
      if (push) begin
        fifo_instr[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]    <= req_pc;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      case (state)
        S_IDLE: if (grant) state <= S_WAIT;
        S_WAIT: if (mem_rvalid) state <= grant ? S_WAIT : S_IDLE;
        S_DROP: if (mem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FQ_STALL_CNT_EN
  // Saturating count of cycles decode waited on an empty queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (instr_ready && !instr_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a scoreboard-driven pop monitor
// and a latency-configurable instruction memory model (rdata = addr ^ 16'hA5A5).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
`ifdef FQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  int grants = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({pc ^ 16'hA5A5, pc});
  endtask

  // Wait (bounded) until every expected instruction has been consumed, then stop popping
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    instr_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Assert reset for two cycles; returns at posedge+1 ready for the next release
  task automatic reset_dut();
    reset = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    mem_gnt = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory model: one outstanding fetch, response lat cycles after the grant
  initial begin
    logic        pend;
    logic [15:0] pend_addr;
    int          cnt;
    pend = 1'b0;
    pend_addr = '0;
    cnt = 0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
        cnt = 0;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = pend_addr ^ 16'hA5A5;
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (reset && mem_req && mem_gnt) begin
        pend = 1'b1;
        pend_addr = mem_addr;
        cnt = lat;
        grants++;
      end
    end
  end

  // Monitor: every accepted instruction is checked against the scoreboard head
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h instr %h, expected no instruction", instr_pc, instr);
      end else begin
        check("pop_instr_pc", {instr, instr_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int g0;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_gnt = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);

    // T1: zero-wait memory, one instruction per cycle
    @(posedge clk);
    #1;
    lat = 1;
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(16'(2 * k));
    reset = 1'b1;
    @(negedge clk);
    check("t1_first_req", 32'(mem_req), 32'd1);
    check("t1_first_addr", 32'(mem_addr), 32'h0000);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (k >= 2) check("t1_stream_valid", 32'(instr_valid), 32'd1);
    end
    drain(5);
    @(posedge clk);
    #1;
    reset_dut();

    // T2: decode stalled, queue fills to exactly DEPTH then resumes
    lat = 1;
    instr_ready = 1'b0;
    g0 = grants;
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("t2_grants", 32'(grants - g0), 32'd4);
    check("t2_full_req", 32'(mem_req), 32'd0);
    check("t2_head_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", 32'(instr_pc), 32'h0000);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(16'(2 * k));
    @(negedge clk);
    check("t2_pop_noreq", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_resume_req", 32'(mem_req), 32'd1);
    check("t2_resume_addr", 32'(mem_addr), 32'h0008);
    drain(20);
    reset_dut();

    // T3: redirect while a fetch is outstanding; stale response dropped
    lat = 3;
    instr_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    exp_q.delete();
    push_exp(16'h0100);
    push_exp(16'h0102);
    @(negedge clk);
    check("t3_redir_req", 32'(mem_req), 32'd0);
    check("t3_redir_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t3_drop_req", 32'(mem_req), 32'd0);
    check("t3_drop_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_stale_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_new_req", 32'(mem_req), 32'd1);
    check("t3_new_addr", 32'(mem_addr), 32'h0100);
    drain(40);
    reset_dut();

    // T4: redirect near the top of memory, PC wraps
    lat = 1;
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    push_exp(16'hFFFC);
    push_exp(16'hFFFE);
    push_exp(16'h0000);
    push_exp(16'h0002);
    reset = 1'b1;
    @(negedge clk);
    check("t4_redir_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t4_req", 32'(mem_req), 32'd1);
    check("t4_addr", 32'(mem_addr), 32'hFFFC);
    drain(30);
    reset_dut();

    // T5: reset mid-WAIT with two queued entries, then held request without grant
    lat = 3;
    instr_ready = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
    end
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    check("t5_pre_pc", 32'(instr_pc), 32'h0000);
    reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(instr_valid), 32'd0);
    check("t5_rst_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_hold_req", 32'(mem_req), 32'd1);
      check("t5_hold_addr", 32'(mem_addr), 32'h0000);
      @(posedge clk);
      #1;
    end
    reset_dut();

    // T6: slow memory, first instruction arrives after exactly six empty cycles
    lat = 5;
    instr_ready = 1'b1;
    push_exp(16'h0000);
    reset = 1'b1;
    first = -1;
`ifdef FQ_STALL_CNT_EN
    check("t6_stall_rst", 32'(stall_cycles), 32'd0);
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        first = k;
`ifdef FQ_STALL_CNT_EN
        check("t6_stall_cycles", 32'(stall_cycles), 32'd6);
`endif
        break;
      end
      @(posedge clk);
      #1;
    end
    check("t6_first_valid_cycle", 32'(first), 32'd6);
    drain(5);
    reset_dut();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit with prefetch buffer for the 16-bit multicycle CPU. Sits directly upstream of the decode stage: issues word-aligned fetch requests to instruction memory, buffers returned 16-bit instructions with their PCs in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. A redirect input flushes the buffer, discards in-flight fetches, and restarts fetching from a new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 16'h0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request valid
- mem_addr  out  16  fetch address; bit 0 always 0
- mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt = handshake)
- mem_rvalid  in  1  response valid; in order; at most one outstanding
- mem_rdata  in  16  instruction word
- redirect  in  1  flush and restart (branch/jump taken)
- redirect_pc  in  16  new fetch PC; bit 0 forced to 0
- instr_valid  out  1  head entry valid
- instr  out  16  head instruction
- instr_pc  out  16  PC of head instruction
- instr_ready  in  1  decode accepts head (instr_valid & instr_ready = pop)
- stall_cycles  out  16  only with FQ_STALL_CNT_EN

## Operation
- Registers: fetch_pc, FIFO (instr + pc per entry), rd/wr pointers, count (0..DEPTH), state, req_pc (PC of outstanding fetch).
- States: IDLE (nothing outstanding), WAIT (one fetch outstanding, response kept), DROP (one fetch outstanding, response discarded).
- space = count + (state != IDLE) < DEPTH, evaluated with WAIT&mem_rvalid counted as a completed entry.
- mem_req = !redirect & space & (IDLE | (WAIT & mem_rvalid)); mem_addr = fetch_pc.
- On mem_req & mem_gnt: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 2 (wraps 16'hFFFE → 16'h0000), state → WAIT.
- WAIT & mem_rvalid: push {mem_rdata, req_pc}; → IDLE unless new grant same cycle (stays WAIT).
- DROP & mem_rvalid: data discarded, → IDLE; mem_req = 0 while in DROP.
- Pop: instr_valid & instr_ready advances rd pointer. Push and pop in same cycle: count unchanged; valid when full (full-queue push never occurs because space gates requests).
- instr_valid = (count != 0) & !redirect; instr/instr_pc driven from head entry.
- Redirect (highest priority): count/pointers cleared, fetch_pc <= {redirect_pc[15:1],1'b0}; IDLE → IDLE; WAIT & !mem_rvalid → DROP; WAIT & mem_rvalid → IDLE, response discarded; DROP stays DROP (→ IDLE if mem_rvalid). Pop in a redirect cycle has no effect. mem_req low in redirect cycle; any ungranted request is withdrawn.
- mem_rvalid in IDLE is a protocol error; ignored.

## Timing
- Reset (reset low, async): mem_req 0 while asserted, state IDLE, count 0, fetch_pc = RESET_PC, instr_valid 0, instr 0, instr_pc 0, stall_cycles 0.
- First cycle after reset release: mem_req = 1, mem_addr = RESET_PC.
- Latency: mem_rvalid at cycle N → instr_valid at cycle N+1.
- Zero-wait memory (gnt same cycle, rvalid next cycle): sustained one instruction per cycle after first.
- mem_addr stable while mem_req high and not granted.
- Redirect at cycle N: instr_valid 0 at N and N+1; mem_req to redirect_pc earliest at N+1 (IDLE) or cycle after stale mem_rvalid (DROP).

## Configuration
- FQ_STALL_CNT_EN defined: stall_cycles port present; increments each cycle instr_ready & !instr_valid, saturates at 16'hFFFF, cleared only by reset.
- Not defined: stall_cycles port and counter absent; all other behaviour identical.

## Test plan
- Reset release, zero-wait memory returning mem_rdata = addr ^ 16'hA5A5, instr_ready = 1 -> instr_pc sequence 0000, 0002, 0004…, one per cycle, instr = pc ^ A5A5.
- instr_ready = 0, DEPTH = 4 -> exactly 4 grants, mem_req stays 0 after, instr_pc 0000 held; raise instr_ready -> 0000, 0002, 0004, 0006 then fetching resumes at 0008.
- Redirect to 16'h0101 while fetch outstanding (WAIT, rvalid 3 cycles later) -> stale word dropped, next mem_addr = 16'h0100, first instr_pc after flush = 0100.
- Redirect to 16'hFFFC, free-running -> instr_pc FFFC, FFFE, 0000, 0002 (wrap).
- Reset asserted mid-WAIT with 2 queued entries -> instr_valid and mem_req 0 immediately; after release mem_addr = RESET_PC.
- FQ_STALL_CNT_EN: memory rvalid delayed 5 cycles per fetch, instr_ready = 1 -> stall_cycles counts empty cycles exactly (e.g. 6 after first instruction); without macro, port absent and sequence identical.
